// File: rtl/bit_pack_ctrl.sv
// ============================================================================
// Module      : bit_pack_ctrl
// Description : Shared packed/serial conversion controller; one W-bit shift
//               register time-shared between a pack and an unpack requester
//               under round-robin arbitration.
//               Optional build macro PACK_MSB_FIRST_EN selects MSB-first.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bit_pack_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pack_req,
  input  logic         pack_bit_valid,
  input  logic         pack_bit,
  output logic         pack_bit_ready,
  output logic [W-1:0] pack_word,
  output logic         pack_done,
  input  logic         unpack_req,
  input  logic [W-1:0] unpack_word,
  output logic         unpack_ack,
  output logic         ser_valid,
  output logic         ser_bit,
  input  logic         ser_ready,
  output logic         unpack_done,
  output logic         busy
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PACK   = 2'd1,
    S_UNPACK = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_shreg, w_shreg_nxt;
  logic [W-1:0]  r_pack_word, w_pack_word_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_last_unpack, w_last_unpack_nxt;
  logic          r_job_unpack, w_job_unpack_nxt;

  logic          w_grant_pack, w_grant_unpack, w_cnt_last;
  logic [W-1:0]  w_pack_shift, w_unpack_shift;
  logic          w_ser_src;

`ifdef PACK_MSB_FIRST_EN
  assign w_pack_shift   = {r_shreg[W-2:0], pack_bit};
  assign w_unpack_shift = {r_shreg[W-2:0], 1'b0};
  assign w_ser_src      = r_shreg[W-1];
`else
  assign w_pack_shift   = {pack_bit, r_shreg[W-1:1]};
  assign w_unpack_shift = {1'b0, r_shreg[W-1:1]};
  assign w_ser_src      = r_shreg[0];
`endif

  // On a tie the requester not served last wins; last_grant resets to unpack.
  assign w_grant_pack   = pack_req & (~unpack_req | r_last_unpack);
  assign w_grant_unpack = unpack_req & (~pack_req | ~r_last_unpack);
  assign w_cnt_last     = (r_cnt == C_CNT_LAST);

  always_comb begin
    w_state_nxt       = r_state;
    w_shreg_nxt       = r_shreg;
    w_pack_word_nxt   = r_pack_word;
    w_cnt_nxt         = r_cnt;
    w_last_unpack_nxt = r_last_unpack;
    w_job_unpack_nxt  = r_job_unpack;
    case (r_state)
      S_IDLE: begin
        if (w_grant_pack) begin
          w_state_nxt       = S_PACK;
          w_last_unpack_nxt = 1'b0;
          w_job_unpack_nxt  = 1'b0;
        end else if (w_grant_unpack) begin
          w_state_nxt       = S_UNPACK;
          w_shreg_nxt       = unpack_word;
          w_last_unpack_nxt = 1'b1;
          w_job_unpack_nxt  = 1'b1;
        end
      end
      S_PACK: begin
        if (pack_bit_valid) begin
          w_shreg_nxt = w_pack_shift;
          if (w_cnt_last) begin
            w_state_nxt     = S_DONE;
            w_pack_word_nxt = w_pack_shift;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_UNPACK: begin
        if (ser_ready) begin
          w_shreg_nxt = w_unpack_shift;
          if (w_cnt_last) w_state_nxt = S_DONE;
          else            w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_shreg       <= '0;
      r_pack_word   <= '0;
      r_cnt         <= '0;
      r_last_unpack <= 1'b1;
      r_job_unpack  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shreg       <= w_shreg_nxt;
      r_pack_word   <= w_pack_word_nxt;
      r_cnt         <= w_cnt_nxt;
      r_last_unpack <= w_last_unpack_nxt;
      r_job_unpack  <= w_job_unpack_nxt;
    end
  end

  assign pack_bit_ready = (r_state == S_PACK);
  assign ser_valid      = (r_state == S_UNPACK);
  assign ser_bit        = ser_valid & w_ser_src;
  assign pack_word      = r_pack_word;
  assign pack_done      = (r_state == S_DONE) & ~r_job_unpack;
  assign unpack_done    = (r_state == S_DONE) & r_job_unpack;
  assign busy           = (r_state != S_IDLE);
  // Held low while reset is asserted even though the state already reads IDLE.
  assign unpack_ack     = ~rst & (r_state == S_IDLE) & w_grant_unpack;

endmodule

`default_nettype wire
